// File: rtl/logic_reduce_pkg.sv
// Shared encodings for the logic reduce unit: operation codes, FSM states
// and mode selects.
package logic_reduce_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;

  localparam logic MODE_PAIR  = 1'b0;
  localparam logic MODE_ACCUM = 1'b1;

endpackage

// File: rtl/logic_reduce_unit_alu.sv
// Combinational core: per-sample bitwise op and the fold of that result into
// the running accumulator.
module logic_op_alu
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  op_e              op,
  input  op_e              op_q,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] fold
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    r = '0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      default: r = '0;
    endcase
  end

  // A NAND burst is the AND-reduction of the per-sample NAND results.
  always_comb begin
    fold = '0;
    case (op_q)
      OP_AND:  fold = acc & r;
      OP_OR:   fold = acc | r;
      OP_XOR:  fold = acc ^ r;
      OP_NAND: fold = acc & r;
      default: fold = '0;
    endcase
  end

endmodule

// File: rtl/logic_reduce_unit.sv
// Bitwise logic unit with a pairwise path (one result per sample) and an
// accumulate path that reduces a burst of up to DEPTH samples into one result.
module logic_reduce_unit
  import logic_reduce_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       op,
  input  logic             mode,
  input  logic [CNT_W-1:0] burst_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  state_e           state, state_d;
  op_e              op_q, op_sel;
  logic [CNT_W-1:0] len_q, len_in, cnt, cnt_inc;
  logic [WIDTH-1:0] acc, r, fold;
  logic             load_pair, start_acc, fold_en, drain;

  // Clamping here is what keeps cnt from ever exceeding DEPTH.
  assign len_in  = (burst_len == '0)     ? CNT_ONE :
                   (burst_len > CNT_MAX) ? CNT_MAX : burst_len;
  assign cnt_inc = cnt + 1'b1;
  assign op_sel  = (state == ACCUM) ? op_q : op_e'(op);
  assign busy    = (state != IDLE);

  logic_op_alu #(.WIDTH(WIDTH)) u_alu (
    .op   (op_sel),
    .op_q (op_q),
    .a    (in_a),
    .b    (in_b),
    .acc  (acc),
    .r    (r),
    .fold (fold)
  );

  // NOTE: asynchronous active-high reset; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    load_pair = 1'b0;
    start_acc = 1'b0;
    fold_en   = 1'b0;
    drain     = out_valid & out_ready;
    case (state)
      IDLE: begin
        // A held pairwise result must leave before a new sample is taken.
        in_ready = ena & (!out_valid | out_ready);
        if (in_valid && in_ready) begin
          if (mode == MODE_PAIR) begin
            load_pair = 1'b1;
          end else begin
            start_acc = 1'b1;
            state_d   = (len_in == CNT_ONE) ? DONE : ACCUM;
          end
        end
      end
      ACCUM: begin
        in_ready = ena;
        if (in_valid && in_ready) begin
          fold_en = 1'b1;
          if (cnt_inc == len_q) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_AND;
      len_q     <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (load_pair) begin
      out_data  <= r;
      out_count <= CNT_ONE;
      out_valid <= 1'b1;
    end else if (start_acc) begin
      op_q  <= op_e'(op);
      len_q <= len_in;
      acc   <= r;
      cnt   <= CNT_ONE;
      if (len_in == CNT_ONE) begin
        out_data  <= r;
        out_count <= CNT_ONE;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (fold_en) begin
      acc <= fold;
      cnt <= cnt_inc;
      if (cnt_inc == len_q) begin
        out_data  <= fold;
        out_count <= len_q;
        out_valid <= 1'b1;
      end
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Scoreboard bench for logic_reduce_unit: directed stimulus pushes expected
// results, a monitor pops and compares them on every output transfer.
module tb_logic_reduce_unit;

  localparam logic [1:0] AND_OP  = 2'b00;
  localparam logic [1:0] OR_OP   = 2'b01;
  localparam logic [1:0] XOR_OP  = 2'b10;
  localparam logic [1:0] NAND_OP = 2'b11;

  typedef struct {
    logic [3:0] data;
    logic [3:0] count;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, ena, in_valid, in_ready, mode, out_valid, out_ready, busy;
  logic [3:0] in_a, in_b, burst_len, out_data, out_count;
  logic [1:0] op;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic_reduce_unit #(.WIDTH(4), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .op        (op),
    .mode      (mode),
    .burst_len (burst_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_result(input logic [3:0] data, input logic [3:0] count);
    exp_t e;
    e.data  = data;
    e.count = count;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o,
                      input logic m, input logic [3:0] len);
    int n;
    in_a = a; in_b = b; op = o; mode = m; burst_len = len;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed output transfer must match the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {28'd0, out_data}, 32'hdead);
        end else begin
          e = exp_q.pop_front();
          check("result_data", {28'd0, out_data}, {28'd0, e.data});
          check("result_count", {28'd0, out_count}, {28'd0, e.count});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ena = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; op = '0; mode = 1'b0; burst_len = '0;

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {28'd0, out_data}, 32'd0);
    check("rst_out_count", {28'd0, out_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready_ena0", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    ena = 1'b1;
    step();

    // 1: pairwise ops back to back
    expect_result(4'b1000, 4'd1);
    expect_result(4'b1110, 4'd1);
    expect_result(4'b0110, 4'd1);
    expect_result(4'b0111, 4'd1);
    send(4'b1100, 4'b1010, AND_OP,  1'b0, 4'd0);
    send(4'b1100, 4'b1010, OR_OP,   1'b0, 4'd0);
    send(4'b1100, 4'b1010, XOR_OP,  1'b0, 4'd0);
    send(4'b1100, 4'b1010, NAND_OP, 1'b0, 4'd0);
    @(negedge clk);
    check("pair_last_valid", {31'd0, out_valid}, 32'd1);
    step();
    @(negedge clk);
    check("pair_valid_drop", {31'd0, out_valid}, 32'd0);
    step();

    // 2: accumulate XOR, burst_len=3
    expect_result(4'b0111, 4'd3);
    send(4'b0001, 4'b0000, XOR_OP, 1'b1, 4'd3);
    @(negedge clk);
    check("xor_busy_1", {31'd0, busy}, 32'd1);
    check("xor_valid_1", {31'd0, out_valid}, 32'd0);
    step();
    send(4'b0010, 4'b0000, XOR_OP, 1'b1, 4'd3);
    @(negedge clk);
    check("xor_valid_2", {31'd0, out_valid}, 32'd0);
    step();
    send(4'b0100, 4'b0000, XOR_OP, 1'b1, 4'd3);
    @(negedge clk);
    check("xor_valid_3", {31'd0, out_valid}, 32'd1);
    check("done_in_ready", {31'd0, in_ready}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd1);
    step();
    @(negedge clk);
    check("xor_idle_busy", {31'd0, busy}, 32'd0);
    check("xor_idle_valid", {31'd0, out_valid}, 32'd0);
    step();

    // 3: accumulate AND with op toggled mid-burst
    expect_result(4'b1010, 4'd2);
    send(4'b1111, 4'b1110, AND_OP, 1'b1, 4'd2);
    send(4'b1011, 4'b1111, OR_OP,  1'b1, 4'd2);
    step();
    step();

    // 4: back-pressure on a pairwise result
    out_ready = 1'b0;
    expect_result(4'b1000, 4'd1);
    expect_result(4'b1110, 4'd1);
    send(4'b1100, 4'b1010, AND_OP, 1'b0, 4'd0);
    in_a = 4'b1100; in_b = 4'b1010; op = OR_OP; mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_data", {28'd0, out_data}, 32'h8);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_data", {28'd0, out_data}, 32'he);
    step();
    step();

    // 5a: burst_len=0 behaves as a single-sample burst
    expect_result(4'b0110, 4'd1);
    send(4'b1100, 4'b1010, XOR_OP, 1'b1, 4'd0);
    @(negedge clk);
    check("len0_valid", {31'd0, out_valid}, 32'd1);
    step();
    step();

    // 5b: burst_len=15 clamps to DEPTH=8
    expect_result(4'b0111, 4'd8);
    for (int i = 0; i < 8; i++) begin
      send(4'(i), 4'b0000, OR_OP, 1'b1, 4'd15);
      if (i == 6) begin
        @(negedge clk);
        check("clamp_valid_7", {31'd0, out_valid}, 32'd0);
        check("clamp_busy_7", {31'd0, busy}, 32'd1);
        step();
      end
    end
    @(negedge clk);
    check("clamp_valid_8", {31'd0, out_valid}, 32'd1);
    check("clamp_in_ready_done", {31'd0, in_ready}, 32'd0);
    step();
    step();

    // 6: ena low mid-burst, then async reset mid-burst
    send(4'b0001, 4'b0000, XOR_OP, 1'b1, 4'd3);
    ena = 1'b0;
    in_a = 4'b0010; in_b = 4'b0000; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ena0_in_ready", {31'd0, in_ready}, 32'd0);
      check("ena0_busy", {31'd0, busy}, 32'd1);
      step();
    end
    in_valid = 1'b0;
    ena = 1'b1;
    send(4'b0010, 4'b0000, XOR_OP, 1'b1, 4'd3);
    @(negedge clk);
    check("ena_frozen_cnt", {31'd0, out_valid}, 32'd0);
    check("ena_still_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_out_data", {28'd0, out_data}, 32'd0);
    check("arst_out_count", {28'd0, out_count}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
